// File: rtl/mem_datapath_if.sv
// Strobe/data bundle for mem_datapath; master drives the strobes, slave is the datapath.
interface mem_datapath_if;
  logic       weA;
  logic       incA;
  logic       weB;
  logic       incB;
  logic [7:0] data_in;
  logic [1:0] rd_sel_b;
  logic [7:0] data_out_b;
  logic [2:0] addr_a;
  logic [1:0] addr_b;
  logic [2:0] b_count;
  logic       done;
  logic       ovf;

  modport master (
    output weA, incA, weB, incB, data_in, rd_sel_b,
    input  data_out_b, addr_a, addr_b, b_count, done, ovf
  );

  modport slave (
    input  weA, incA, weB, incB, data_in, rd_sel_b,
    output data_out_b, addr_a, addr_b, b_count, done, ovf
  );
endinterface

// File: rtl/mem_datapath.sv
// Pair-sum datapath: memA (8x8) words summed pairwise into memB (4x8); MEM_DATAPATH_SAT_EN saturates sums.
// Latency: B write readable one cycle after the weB edge; no backpressure, every strobe is taken.
module mem_datapath (
  input logic           clock,
  input logic           reset,
  mem_datapath_if.slave bus
);

  logic [7:0] mem_a [8];
  logic [7:0] mem_b [4];
  logic [7:0] hold_a;
  logic [2:0] addr_a;
  logic [1:0] addr_b;
  logic [2:0] b_count;
  logic       done;
  logic       ovf;
  logic [8:0] sum9;
  logic [7:0] sum8;

  // Sum of the captured word and the word currently under addr_a, pre-edge values.
  assign sum9 = {1'b0, hold_a} + {1'b0, mem_a[addr_a]};

`ifdef MEM_DATAPATH_SAT_EN
  assign sum8 = sum9[8] ? 8'hFF : sum9[7:0];
`else
  assign sum8 = sum9[7:0];
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) mem_a[i] <= '0;
      for (int i = 0; i < 4; i++) mem_b[i] <= '0;
      hold_a  <= '0;
      addr_a  <= '0;
      addr_b  <= '0;
      b_count <= '0;
      done    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (bus.weA) mem_a[addr_a] <= bus.data_in;
      // hold_a samples the pre-write word even when weA hits the same address.
      if (bus.incA) begin
        addr_a <= addr_a + 3'd1;
        hold_a <= mem_a[addr_a];
      end
      if (bus.weB) begin
        mem_b[addr_b] <= sum8;
        if (sum9[8]) ovf <= 1'b1;
        if (b_count != 3'd4) b_count <= b_count + 3'd1;
      end
      if (bus.incB) addr_b <= addr_b + 2'd1;
      done <= bus.weB && (addr_b == 2'd3);
    end
  end

  assign bus.data_out_b = mem_b[bus.rd_sel_b];
  assign bus.addr_a     = addr_a;
  assign bus.addr_b     = addr_b;
  assign bus.b_count    = b_count;
  assign bus.done       = done;
  assign bus.ovf        = ovf;

endmodule

// File: tb/tb_mem_datapath.sv
// Directed plus random bench for mem_datapath against an array-based reference model.
module tb_mem_datapath;
  logic clock;
  logic reset;
  mem_datapath_if bus ();

  mem_datapath dut (.clock(clock), .reset(reset), .bus(bus));

  initial clock = 1'b0;
  always #10 clock = ~clock;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_a [8];
  int m_b [4];
  int m_hold, m_pa, m_pb, m_cnt, m_done, m_ovf;

  function automatic int sat8(input int s);
`ifdef MEM_DATAPATH_SAT_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_a[i] = 0;
    for (int i = 0; i < 4; i++) m_b[i] = 0;
    m_hold = 0; m_pa = 0; m_pb = 0; m_cnt = 0; m_done = 0; m_ovf = 0;
  endtask

  task automatic model_edge(input bit wa, input bit ia, input bit wb, input bit ib, input int d);
    int s;
    int olda;
    s    = m_hold + m_a[m_pa];
    olda = m_a[m_pa];
    m_done = (wb && m_pb == 3) ? 1 : 0;
    if (wb) begin
      m_b[m_pb] = sat8(s);
      if (s > 255) m_ovf = 1;
      if (m_cnt < 4) m_cnt++;
    end
    if (wa) m_a[m_pa] = d;
    if (ia) begin
      m_hold = olda;
      m_pa   = (m_pa + 1) % 8;
    end
    if (ib) m_pb = (m_pb + 1) % 4;
  endtask

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic read_b(input int idx, output logic [7:0] v);
    bus.rd_sel_b = idx[1:0];
    #1;
    v = bus.data_out_b;
  endtask

  task automatic check_all(input string tag);
    logic [7:0] v;
    chk({tag, ".addr_a"},  {6'd0, bus.addr_a},  m_pa[8:0]);
    chk({tag, ".addr_b"},  {7'd0, bus.addr_b},  m_pb[8:0]);
    chk({tag, ".b_count"}, {6'd0, bus.b_count}, m_cnt[8:0]);
    chk({tag, ".done"},    {8'd0, bus.done},    m_done[8:0]);
    chk({tag, ".ovf"},     {8'd0, bus.ovf},     m_ovf[8:0]);
    for (int i = 0; i < 4; i++) begin
      read_b(i, v);
      chk($sformatf("%s.memB[%0d]", tag, i), {1'b0, v}, m_b[i][8:0]);
    end
  endtask

  task automatic step(input string tag, input bit wa, input bit ia, input bit wb, input bit ib,
                      input int d);
    bus.weA = wa; bus.incA = ia; bus.weB = wb; bus.incB = ib;
    bus.data_in = d[7:0];
    @(posedge clock);
    model_edge(wa, ia, wb, ib, d);
    #1;
    bus.weA = 1'b0; bus.incA = 1'b0; bus.weB = 1'b0; bus.incB = 1'b0;
    check_all(tag);
  endtask

  // Assert reset between edges, hold it across an edge with every strobe active, then release.
  task automatic mid_reset(input string tag);
    reset = 1'b1;
    #1;
    model_reset();
    check_all({tag, ".async"});
    bus.weA = 1'b1; bus.incA = 1'b1; bus.weB = 1'b1; bus.incB = 1'b1;
    bus.data_in = 8'hA5;
    @(posedge clock);
    #1;
    bus.weA = 1'b0; bus.incA = 1'b0; bus.weB = 1'b0; bus.incB = 1'b0;
    check_all({tag, ".held"});
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] v;
    bus.weA = 1'b0; bus.incA = 1'b0; bus.weB = 1'b0; bus.incB = 1'b0;
    bus.data_in = '0; bus.rd_sel_b = '0;
    reset = 1'b1;
    model_reset();
    #3;
    check_all("reset");
    @(posedge clock);
    #2 reset = 1'b0;

    // Fill and wrap
    for (int i = 0; i < 8; i++) step("fill", 1, 1, 0, 0, (i + 1) * 10);
    chk("fill.addr_a_wrapped", {6'd0, bus.addr_a}, 9'd0);

    // First pair sum: 10 + 20
    step("pair.incA", 0, 1, 0, 0, 0);
    step("pair.weB", 0, 0, 1, 0, 0);
    read_b(0, v);
    chk("pair.memB0_const", {1'b0, v}, 9'd30);
    chk("pair.b_count_const", {6'd0, bus.b_count}, 9'd1);

    // B sequence: three more pair sums, done on the addr_b==3 write
    for (int r = 0; r < 3; r++) begin
      step("bseq.incB", 0, 0, 0, 1, 0);
      step("bseq.incA", 0, 1, 0, 0, 0);
      step("bseq.incA", 0, 1, 0, 0, 0);
      step("bseq.weB", 0, 0, 1, 0, 0);
    end
    chk("bseq.done_const", {8'd0, bus.done}, 9'd1);
    read_b(3, v);
    chk("bseq.memB3_const", {1'b0, v}, 9'd150);
    chk("bseq.b_count_const", {6'd0, bus.b_count}, 9'd4);
    step("bseq.idle", 0, 0, 0, 0, 0);
    chk("bseq.done_cleared", {8'd0, bus.done}, 9'd0);
    step("bseq.sat_cnt", 0, 0, 1, 0, 0);

    // Overflow: 200 + 100
    mid_reset("ovf.rst");
    step("ovf.wa0", 1, 0, 0, 0, 200);
    step("ovf.inc", 0, 1, 0, 0, 0);
    step("ovf.wa1", 1, 0, 0, 0, 100);
    step("ovf.weB", 0, 0, 1, 0, 0);
    read_b(0, v);
`ifdef MEM_DATAPATH_SAT_EN
    chk("ovf.memB0_const", {1'b0, v}, 9'd255);
`else
    chk("ovf.memB0_const", {1'b0, v}, 9'd44);
`endif
    chk("ovf.flag_const", {8'd0, bus.ovf}, 9'd1);

    // Simultaneous strobes, then a B write that exposes the captured hold word
    step("simul.all", 1, 1, 1, 1, 77);
    step("simul.all2", 1, 1, 1, 1, 33);
    step("simul.weB", 0, 0, 1, 0, 0);

    // Reset in the middle of a B sequence
    mid_reset("mid.rst0");
    for (int i = 0; i < 4; i++) step("mid.fill", 1, 1, 0, 0, (i + 1) * 10);
    step("mid.incA", 0, 1, 0, 0, 0);
    step("mid.weB", 0, 0, 1, 0, 0);
    step("mid.incB", 0, 0, 0, 1, 0);
    step("mid.incA", 0, 1, 0, 0, 0);
    mid_reset("mid.rst1");
    step("mid.after", 0, 0, 1, 1, 0);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 49) == 0) mid_reset("rnd.rst");
      else step("rnd", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                int'($urandom_range(0, 255)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_datapath.md
MEM_DATAPATH -- requirements
Module: mem_datapath

Interface
REQ-001 SHALL have port: clock  input  1  rising-edge clock.
REQ-002 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: weA  input  1  write data_in into memory A at addr_a.
REQ-004 SHALL have port: incA  input  1  advance addr_a; capture current A word into hold register.
REQ-005 SHALL have port: weB  input  1  write pair-sum into memory B at addr_b.
REQ-006 SHALL have port: incB  input  1  advance addr_b.
REQ-007 SHALL have port: data_in  input  8  word written to memory A.
REQ-008 SHALL have port: rd_sel_b  input  2  read index into memory B, independent of addr_b.
REQ-009 SHALL have port: data_out_b  output  8  memB[rd_sel_b], combinational read.
REQ-010 SHALL have port: addr_a  output  3  current memory A pointer.
REQ-011 SHALL have port: addr_b  output  2  current memory B pointer.
REQ-012 SHALL have port: b_count  output  3  number of B writes since reset, saturating at 4.
REQ-013 SHALL have port: done  output  1  one-cycle pulse on the B write at addr_b==3.
REQ-014 SHALL have port: ovf  output  1  sticky flag: some B write had an 8-bit sum carry.

Function
REQ-015 SHALL contain memA (8x8) and memB (4x8); all state updates SHALL occur on the rising clock edge.
REQ-016 SHALL write memA[addr_a] <= data_in on an edge with weA=1, using the pre-edge addr_a.
REQ-017 SHALL, on an edge with incA=1, set addr_a <= addr_a+1 mod 8 (7 wraps to 0) and hold_a <= memA[addr_a] (pre-edge address, pre-edge contents).
REQ-018 SHALL, on an edge with weA=1 and incA=1, write first and increment after; hold_a SHALL take the old memA contents, not data_in.
REQ-019 SHALL form sum9 = hold_a + memA[addr_a] as a 9-bit combinational value.
REQ-020 SHALL, on an edge with weB=1, write memB[addr_b] <= sum8, where sum8 is defined by REQ-030/031, using the pre-edge addr_b.
REQ-021 SHALL, on an edge with incB=1, set addr_b <= addr_b+1 mod 4; with weB and incB both set, write at the old address, then increment.
REQ-022 SHALL set ovf <= 1 on any weB edge where sum9[8]=1; ovf SHALL clear only on reset.
REQ-023 SHALL increment b_count on each weB edge, holding at 4 thereafter.
REQ-024 SHALL assert done for exactly one cycle following an edge with weB=1 and pre-edge addr_b==3; otherwise done=0.
REQ-025 SHALL perform simultaneous weA/incA/weB/incB operations independently in the same cycle; sum9 SHALL use pre-edge values.
REQ-026 SHALL have latency as follows: a written word is visible on data_out_b the cycle after the weB edge.

Reset
REQ-027 SHALL, on reset=1 (asynchronous), immediately clear addr_a, addr_b, hold_a, b_count, done and ovf to 0, and clear all memA/memB words to 0.
REQ-028 SHALL hold all state at reset values while reset=1, ignoring weA/incA/weB/incB; an assertion mid-sequence SHALL abort it with no partial write.
REQ-029 SHALL perform its first update on the first rising edge after reset deasserts.

Configuration
REQ-030 SHALL, with macro MEM_DATAPATH_SAT_EN defined, saturate sum8 = sum9[8] ? 8'hFF : sum9[7:0].
REQ-031 SHALL, without MEM_DATAPATH_SAT_EN, wrap sum8 = sum9[7:0]; ovf behaviour SHALL be identical in both builds.

Verification
REQ-032 SHALL verify fill and wrap: reset; 8 cycles weA=incA=1 with data_in=10,20,...,80 -> memA[0..7]=10..80, addr_a=0.
REQ-033 SHALL verify a pair sum: after REQ-032, one incA cycle (hold_a=10, addr_a=1), then weB=1 -> memB[0]=30, b_count=1, ovf=0.
REQ-034 SHALL verify the B sequence: after REQ-033, repeat {incB; incA; incA; weB} three times -> memB[1..3]=70,110,150; done pulses once; b_count=4; addr_b=3.
REQ-035 SHALL verify overflow: memA[0]=200, memA[1]=100, incA then weB -> memB[0]=255 with MEM_DATAPATH_SAT_EN, 44 without; ovf=1 in both.
REQ-036 SHALL verify simultaneous events: weA=incA=weB=incB=1 in one cycle -> the A write, B write (pre-edge sum) and both increments all occur; hold_a takes the old memA word.
REQ-037 SHALL verify reset mid-operation: assert reset between clock edges during REQ-034 -> all outputs 0 immediately, memB reads 0, and no write occurs while reset=1.
